gf_div: RTL
===========

# gf_div

Sequential GF(2^8) divider for the RS codec datapath, field polynomial x^8+x^4+x^3+x^2+1 (0x11D), the same field as the codec's combinational multiplier. It computes quot = num · den⁻¹, forming den⁻¹ = den^254 by iterated square-and-multiply. It serves the decoder back-end, for example Forney error-magnitude evaluation, where a division is needed once per error location and a multi-cycle, low-area unit is sufficient.

## Interface
- `W`, 8: symbol width. Fixed for the 0x11D field; not to be overridden.
- `POLY`, 8'h1D: low byte of the field polynomial; x^8 is implicit.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `in_valid` in 1: operands present on `num`/`den`.
- `in_ready` out 1: unit can accept operands.
- `num` in 8: dividend.
- `den` in 8: divisor.
- `out_valid` out 1: result held on `quot`/`div0`.
- `out_ready` in 1: consumer accepts the result.
- `quot` out 8: quotient.
- `div0` out 1: `den` was 0 for this result.

## Operation
- FSM has four states: IDLE, ITER, FINAL, DONE.
- IDLE:
  - `in_ready`=1.
  - An operation is accepted when `in_valid`&`in_ready` at a rising edge. On acceptance: `num_r`<=num, `sq`<=den, `acc`<=8'h01, `cnt`<=0, `div0_r`<=(den==0); go to ITER.
- ITER:
  - Each cycle: `sq`<=sq², `acc`<=acc·sq², `cnt`<=cnt+1.
  - Leave for FINAL after 7 ITER cycles (cnt==6 → FINAL). At that point `acc` = den^(2+4+…+128) = den^254.
- FINAL: `quot`<=num_r·acc, `div0`<=div0_r; go to DONE.
- DONE:
  - `out_valid`=1; `quot`/`div0` are held stable.
  - On `out_ready` go to IDLE.
  - `out_valid` may stay high indefinitely; there is no timeout.
- den==0 takes the same path and latency. The result is 0^254·num = 0, so `quot`=0 with `div0`=1; no special-case datapath.
- num==0 gives `quot`=0 with `div0`=0, unless den==0.
- All arithmetic is GF(2^8): addition is XOR, multiplication is polynomial product mod 0x11D. No integer carries anywhere.
- `in_valid` while not in IDLE is ignored; the operands are not latched.
- Reset:
  - `rst` at any edge, including mid-ITER/FINAL/DONE, forces IDLE and discards the in-flight operation.
  - Reset values: `in_ready`=1 after reset, `out_valid`=0, `quot`=8'h00, `div0`=0, `cnt`=0.

## Timing
- Acceptance edge = cycle 0. ITER occupies cycles 1–7 and FINAL cycle 8. `out_valid` rises after the edge ending cycle 8, i.e. it is visible in cycle 9.
- Latency is fixed: 9 cycles from acceptance to `out_valid`, independent of operand values.
- `in_ready` is combinational from state: high only in IDLE.
- DONE→IDLE on the `out_ready` edge. The next acceptance is possible no earlier than the following edge.
- Minimum initiation interval is 10 cycles with `out_ready` tied high.
- `in_ready` and `out_valid` are never high in the same cycle.
- `out_ready` outside DONE has no effect.
- Combinational path per cycle: one squarer feeding one general multiplier (the ITER `acc` update). Depth is about 2 GF-multiplier levels; no further retiming is required.

## Structure
- A shared package `gf256_pkg` holds:
  - `GF_POLY` = 8'h1D and `GF_ONE` = 8'h01.
  - The state enum {IDLE, ITER, FINAL, DONE}.
  - `ITER_LAST` = 3'd6.
- One sub-module, `gf_mul`: a combinational two-operand GF(2^8) multiplier (a·b mod 0x11D, shift-and-reduce loop unrolled).
- `gf_mul` is instantiated twice:
  - u_sq: sq·sq.
  - u_acc: `acc`·u_sq.y in ITER, `num_r`·`acc` in FINAL, operand-muxed by state.
- Registers: `num_r`, `sq`, `acc`, `cnt`, `div0_r`, `quot`, `div0`, `state`.

## Test plan
- Reset, then num=8'h01, den=8'h02 → `out_valid` in cycle 9, `quot`=8'h8E, `div0`=0.
- num=8'h1D, den=8'h02 → `quot`=8'h80. Then num=8'h04, den=8'h02 → `quot`=8'h02, back-to-back with `out_ready`=1; the second acceptance is 10 cycles after the first.
- Identity checks:
  - num=8'hA7, den=8'h01 → `quot`=8'hA7.
  - num=8'h53, den=8'h53 → `quot`=8'h01.
  - num=8'h00, den=8'h35 → `quot`=8'h00, `div0`=0.
- Zero divisor: num=8'h03, den=8'h00 → `quot`=8'h00, `div0`=1, latency still 9.
- Backpressure and bad input:
  - Hold `out_ready`=0 for 20 cycles → `quot`/`div0` stable, `in_ready`=0. `in_valid` pulses during this window are not accepted.
  - Then `out_ready`=1 → IDLE next cycle.
- Reset and exhaustive sweep:
  - Assert `rst` in cycle 4 of an operation → next cycle `out_valid`=0, `in_ready`=1, `quot`=0; a new operation then completes correctly.
  - Sweep all 255 nonzero den with num=8'h01, checking `quot`·den==1 against the `gf_mul` reference model.

Source files
------------

// File: rtl/gf256_pkg.sv
// gf256_pkg: shared definitions for the GF(2^8) arithmetic blocks of the
// RS codec. The field is defined by x^8+x^4+x^3+x^2+1 (0x11D). Only the
// low byte of the polynomial is stored here because x^8 is implicit.
//
// Contents:
//   GF_POLY   - low byte of the field polynomial
//   GF_ONE    - multiplicative identity
//   ITER_LAST - last value of the square-and-multiply counter
//   state_t   - divider control states
package gf256_pkg;

  localparam logic [7:0] GF_POLY   = 8'h1D;
  localparam logic [7:0] GF_ONE    = 8'h01;

  // den^254 = den^(2+4+...+128) takes seven square-and-multiply steps.
  // The counter runs 0..6.
  localparam logic [2:0] ITER_LAST = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gf_mul.sv
// gf_mul: combinational GF(2^8) multiplier, y = a*b mod (x^8 + POLY).
// The shift-and-reduce loop is fully unrolled. Each step conditionally adds
// the current multiple of a to the product. It then multiplies that multiple
// by x, folding the overflow bit back in through POLY.
//
// Ports:
//   a, b : operands
//   y    : product
module gf_mul #(
  parameter logic [7:0] POLY = 8'h1D
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [7:0] prod;
  logic [7:0] shifted;

  always_comb begin
    prod    = 8'h00;
    shifted = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        prod = prod ^ shifted;
      end
      shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? POLY : 8'h00);
    end
    y = prod;
  end

endmodule

// File: rtl/gf_div.sv
// gf_div: sequential GF(2^8) divider for the RS decoder back-end, for
// example Forney error-magnitude evaluation.
//
// The unit computes quot = num * den^-1. The inverse is formed as
// den^-1 = den^254 by seven square-and-multiply steps, and a final step
// multiplies by num. Latency is a fixed 9 cycles from acceptance to
// out_valid, and the unit handles one operation at a time.
//
// den == 0 follows the same path. The result comes out as 0 naturally, and
// div0 flags it.
//
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is high only in IDLE)
//   num, den             : dividend and divisor
//   out_valid / out_ready: result handshake (out_valid is high only in DONE)
//   quot, div0           : quotient and divide-by-zero flag, held in DONE
module gf_div
  import gf256_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [7:0] POLY = GF_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic         div0
);

  state_t       state;
  state_t       state_n;

  logic [W-1:0] num_r;
  logic [W-1:0] sq;
  logic [W-1:0] acc;
  logic [2:0]   cnt;
  logic         div0_r;

  logic [W-1:0] sq2;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_y;

  // Squarer. Across ITER, sq walks den^2, den^4, ..., den^128.
  gf_mul #(.POLY(POLY)) u_sq (
    .a (sq),
    .b (sq),
    .y (sq2)
  );

  // One general multiplier is shared between the two steps. In ITER it
  // accumulates acc * sq^2. In FINAL it forms num_r * den^254.
  assign mul_a = (state == FINAL) ? num_r : acc;
  assign mul_b = (state == FINAL) ? acc   : sq2;

  gf_mul #(.POLY(POLY)) u_acc (
    .a (mul_a),
    .b (mul_b),
    .y (mul_y)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. in_valid matters only in IDLE, and out_ready
  // matters only in DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = ITER;
        end
      end
      ITER: begin
        if (cnt == ITER_LAST) begin
          state_n = FINAL;
        end
      end
      FINAL: begin
        state_n = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath registers. The operands are captured only on acceptance in
  // IDLE. quot and div0 change only in FINAL, so they stay stable through
  // DONE and afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_r  <= '0;
      sq     <= '0;
      acc    <= GF_ONE;
      cnt    <= 3'd0;
      div0_r <= 1'b0;
      quot   <= '0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            num_r  <= num;
            sq     <= den;
            acc    <= GF_ONE;
            cnt    <= 3'd0;
            div0_r <= (den == '0);
          end
        end
        ITER: begin
          sq  <= sq2;
          acc <= mul_y;
          cnt <= cnt + 3'd1;
        end
        FINAL: begin
          quot <= mul_y;
          div0 <= div0_r;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
